ysyx_24080006_xbar: RTL
=======================

# ysyx_24080006_xbar

AXI4 address-decoding router between the core's single upstream master port (output of the IFU/LSU read arbiter) and two downstream targets: the SoC bus and the core-local CLINT. Read and write channels are routed by independent FSMs, one transaction in flight per direction. Writes aimed at the read-only CLINT window are absorbed locally and answered with SLVERR. Sits between the arbiter and the core's top-level AXI master port.

## Interface
Parameters:
- CLINT_BASE, 32'h0200_0000, CLINT window base address.
- CLINT_MASK, 32'hFFFF_0000, address bits compared against CLINT_BASE.

Ports:
- clock  input  1  single clock. One clock; reset is synchronous and active-high.
- reset  input  1  synchronous, active-high reset.
- axi_in  ysyx_24080006_axi.slave  bundle  upstream port from the arbiter.
- axi_soc  ysyx_24080006_axi.master  bundle  SoC bus target.
- axi_clint  ysyx_24080006_axi.master  bundle  CLINT target. Only AR/R are used; AW/W valids tied 0, bready tied 0.

## Operation
- Decode: hit_clint = (addr & CLINT_MASK) == CLINT_BASE. All other addresses go to SoC.
- Read FSM states: R_IDLE, R_SOC, R_CLINT.
  - R_IDLE: on axi_in.arvalid, go to R_CLINT if hit_clint(araddr), else R_SOC.
  - R_SOC / R_CLINT: AR and R are connected combinationally to the selected target (arvalid, araddr, arid, arlen, arsize, arburst down; arready, rvalid, rdata, rresp, rlast, rid up; rready down).
  - Return to R_IDLE on the cycle where rvalid && rready && rlast on the selected target.
- Write FSM states: W_IDLE, W_SOC, W_ERR, W_ERR_B.
  - W_IDLE: on axi_in.awvalid, go to W_ERR if hit_clint(awaddr), else W_SOC.
  - W_SOC: AW, W and B are wired to axi_soc. Return to W_IDLE on bvalid && bready.
  - W_ERR:
    - awready = 1 until AW handshakes; awid is latched at that handshake.
    - wready = 1 until W handshakes with wlast.
    - Go to W_ERR_B when both are done; AW and W may complete in either order or in the same cycle.
  - W_ERR_B: bvalid = 1, bresp = 2'b10, bid = latched awid. Go to W_IDLE on bready.
- Unselected target: all master-driven valids and readies are 0; address/data fields are don't-care.
- Upstream in IDLE states: arready, awready, wready, rvalid and bvalid are all 0.
- Read and write FSMs are fully independent. A simultaneous AR and AW in the same cycle is accepted by both.

## Timing
- Reset: both FSMs go to IDLE. All upstream ready/valid outputs and all downstream valid/ready outputs are 0. The latched awid and the AW-done/W-done flags are cleared.
- Address phase: one cycle of decode latency. arvalid seen in R_IDLE at cycle N is forwarded downstream at N+1, and the earliest AR handshake is at N+1. The same applies to AW.
- Data and response paths add zero cycles (combinational pass-through).
- Back-to-back transactions: after the last-beat handshake at cycle M, the FSM is IDLE at M+1. The next arvalid is decoded at M+1 and forwarded at M+2.
- Error-path write: earliest bvalid is 2 cycles after the AW/W handshake cycle.
- Reset mid-transaction: the FSMs abort to IDLE and no response is generated. Downstream targets are reset by the same signal.
- Upstream must hold arvalid/awvalid stable until the handshake, per AXI. The FSMs do not re-decode in non-IDLE states.

## Structure
- Shared package ysyx_24080006_pkg gets:
  - the xbar_rd_state_e and xbar_wr_state_e enums;
  - default CLINT_BASE and CLINT_MASK constants;
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - a hit_clint decode function.
- Sub-module ysyx_24080006_xbar_werr holds the W_ERR/W_ERR_B write-error responder (AW/W-done flags, latched awid, B generation). The top holds the two FSMs and the muxing.

## Test plan
- SoC read: araddr=32'h3000_0000, arlen=0. AR is forwarded to axi_soc one cycle later; rdata=32'hDEADBEEF returns upstream the same cycle; FSM is back in R_IDLE the cycle after the R handshake.
- CLINT read: araddr=32'h0200_BFF8, arlen=0. Only axi_clint.arvalid rises; axi_soc.arvalid stays 0; rdata from the CLINT passes through.
- SoC burst read: arlen=3. FSM stays in R_SOC for 4 beats and leaves only on rlast.
- CLINT write: awaddr=32'h0200_0000, awid=4'h5, with W presented one cycle after AW. Upstream gets bresp=2'b10, bid=4'h5. axi_soc.awvalid and axi_soc.wvalid stay 0 throughout.
- Concurrent traffic: SoC write to 32'h8000_0000 and CLINT read issued in the same cycle. Both complete independently, with bresp=0 and the correct rdata.
- Reset asserted while in R_SOC with an rvalid beat pending: the next cycle upstream rvalid=0, arready=0, and the FSM is in R_IDLE.

Source files
------------

// File: rtl/ysyx_24080006_pkg.sv
// Shared definitions for the ysyx_24080006 core bus fabric.
// Provides the AXI field widths, the crossbar FSM state types, the default
// CLINT window, the AXI response codes and the CLINT address decode helper.
package ysyx_24080006_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ID_W   = 4;

  localparam logic [31:0] DEFAULT_CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] DEFAULT_CLINT_MASK = 32'hFFFF_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_SOC,
    R_CLINT
  } xbar_rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SOC,
    W_ERR,
    W_ERR_B
  } xbar_wr_state_e;

  function automatic logic hit_clint(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ysyx_24080006_axi.sv
// AXI4 bundle used between the core's arbiter, crossbar and bus targets.
// modport master: drives AW/W/AR requests, bready and rready.
// modport slave : drives the ready signals of AW/W/AR plus the B and R channels.
interface ysyx_24080006_axi;
  import ysyx_24080006_pkg::*;

  logic                  awvalid;
  logic                  awready;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [AXI_ID_W-1:0]   awid;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;

  logic                  wvalid;
  logic                  wready;
  logic [AXI_DATA_W-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic [AXI_ID_W-1:0]   bid;

  logic                  arvalid;
  logic                  arready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_ID_W-1:0]   arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;

  logic                  rvalid;
  logic                  rready;
  logic [1:0]            rresp;
  logic [AXI_DATA_W-1:0] rdata;
  logic                  rlast;
  logic [AXI_ID_W-1:0]   rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    output rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rresp, rdata, rlast, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    input  rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rresp, rdata, rlast, rid
  );

endinterface

// File: rtl/ysyx_24080006_xbar_werr.sv
// Local write-error responder for writes aimed at the read-only CLINT window.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   err_active          : write FSM is collecting AW/W for the error path
//   resp_active         : write FSM is presenting the error response
//   awvalid/awid        : upstream write address handshake inputs
//   wvalid/wlast        : upstream write data handshake inputs
//   bready              : upstream response ready
//   awready/wready      : readies returned upstream while collecting
//   bvalid/bresp/bid    : SLVERR response carrying the latched awid
//   done                : both AW and the last W beat have been absorbed
module ysyx_24080006_xbar_werr
  import ysyx_24080006_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                err_active,
  input  logic                resp_active,
  input  logic                awvalid,
  input  logic [AXI_ID_W-1:0] awid,
  input  logic                wvalid,
  input  logic                wlast,
  input  logic                bready,
  output logic                awready,
  output logic                wready,
  output logic                bvalid,
  output logic [1:0]          bresp,
  output logic [AXI_ID_W-1:0] bid,
  output logic                done
);

  logic                aw_done;
  logic                w_done;
  logic [AXI_ID_W-1:0] id_q;

  assign awready = err_active & ~aw_done;
  assign wready  = err_active & ~w_done;
  // done uses only the registered flags, so the response phase starts one
  // cycle after the later of the two handshakes has been recorded.
  assign done    = aw_done & w_done;
  assign bvalid  = resp_active;
  assign bresp   = RESP_SLVERR;
  assign bid     = id_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      id_q    <= '0;
    end else if (resp_active && bready) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_done <= 1'b1;
        id_q    <= awid;
      end
      if (wvalid && wready && wlast) begin
        w_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_24080006_xbar.sv
// AXI4 address-decoding router: one upstream master port to the SoC bus and
// the core-local CLINT. Independent read and write FSMs, one transaction in
// flight per direction. CLINT writes are absorbed and answered with SLVERR.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   axi_in       : upstream port from the IFU/LSU arbiter
//   axi_soc      : SoC bus target (all channels)
//   axi_clint    : CLINT target (AR/R only; AW/W/B held idle)
module ysyx_24080006_xbar
  import ysyx_24080006_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = DEFAULT_CLINT_BASE,
  parameter logic [31:0] CLINT_MASK = DEFAULT_CLINT_MASK
) (
  input logic              clock,
  input logic              reset,
  ysyx_24080006_axi.slave  axi_in,
  ysyx_24080006_axi.master axi_soc,
  ysyx_24080006_axi.master axi_clint
);

  xbar_rd_state_e rd_state;
  xbar_wr_state_e wr_state;

  logic rd_soc, rd_clint;
  logic wr_soc, wr_err, wr_errb;

  logic                err_awready, err_wready, err_bvalid, err_done;
  logic [1:0]          err_bresp;
  logic [AXI_ID_W-1:0] err_bid;

  assign rd_soc   = (rd_state == R_SOC);
  assign rd_clint = (rd_state == R_CLINT);
  assign wr_soc   = (wr_state == W_SOC);
  assign wr_err   = (wr_state == W_ERR);
  assign wr_errb  = (wr_state == W_ERR_B);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= R_IDLE;
    end else begin
      case (rd_state)
        R_IDLE:  if (axi_in.arvalid)
                   rd_state <= hit_clint(axi_in.araddr, CLINT_BASE, CLINT_MASK) ? R_CLINT : R_SOC;
        R_SOC:   if (axi_soc.rvalid && axi_soc.rready && axi_soc.rlast) rd_state <= R_IDLE;
        R_CLINT: if (axi_clint.rvalid && axi_clint.rready && axi_clint.rlast) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= W_IDLE;
    end else begin
      case (wr_state)
        W_IDLE:  if (axi_in.awvalid)
                   wr_state <= hit_clint(axi_in.awaddr, CLINT_BASE, CLINT_MASK) ? W_ERR : W_SOC;
        W_SOC:   if (axi_soc.bvalid && axi_soc.bready) wr_state <= W_IDLE;
        W_ERR:   if (err_done) wr_state <= W_ERR_B;
        W_ERR_B: if (axi_in.bready) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  ysyx_24080006_xbar_werr u_werr (
    .clock       (clock),
    .reset       (reset),
    .err_active  (wr_err),
    .resp_active (wr_errb),
    .awvalid     (axi_in.awvalid),
    .awid        (axi_in.awid),
    .wvalid      (axi_in.wvalid),
    .wlast       (axi_in.wlast),
    .bready      (axi_in.bready),
    .awready     (err_awready),
    .wready      (err_wready),
    .bvalid      (err_bvalid),
    .bresp       (err_bresp),
    .bid         (err_bid),
    .done        (err_done)
  );

  // Read address/data fields go to both targets; only valids/readies select.
  assign axi_soc.arvalid   = rd_soc & axi_in.arvalid;
  assign axi_soc.araddr    = axi_in.araddr;
  assign axi_soc.arid      = axi_in.arid;
  assign axi_soc.arlen     = axi_in.arlen;
  assign axi_soc.arsize    = axi_in.arsize;
  assign axi_soc.arburst   = axi_in.arburst;
  assign axi_soc.rready    = rd_soc & axi_in.rready;

  assign axi_clint.arvalid = rd_clint & axi_in.arvalid;
  assign axi_clint.araddr  = axi_in.araddr;
  assign axi_clint.arid    = axi_in.arid;
  assign axi_clint.arlen   = axi_in.arlen;
  assign axi_clint.arsize  = axi_in.arsize;
  assign axi_clint.arburst = axi_in.arburst;
  assign axi_clint.rready  = rd_clint & axi_in.rready;

  assign axi_in.arready = (rd_soc & axi_soc.arready) | (rd_clint & axi_clint.arready);
  assign axi_in.rvalid  = (rd_soc & axi_soc.rvalid)  | (rd_clint & axi_clint.rvalid);
  assign axi_in.rdata   = rd_clint ? axi_clint.rdata : axi_soc.rdata;
  assign axi_in.rresp   = rd_clint ? axi_clint.rresp : axi_soc.rresp;
  assign axi_in.rlast   = rd_clint ? axi_clint.rlast : axi_soc.rlast;
  assign axi_in.rid     = rd_clint ? axi_clint.rid   : axi_soc.rid;

  assign axi_soc.awvalid = wr_soc & axi_in.awvalid;
  assign axi_soc.awaddr  = axi_in.awaddr;
  assign axi_soc.awid    = axi_in.awid;
  assign axi_soc.awlen   = axi_in.awlen;
  assign axi_soc.awsize  = axi_in.awsize;
  assign axi_soc.awburst = axi_in.awburst;
  assign axi_soc.wvalid  = wr_soc & axi_in.wvalid;
  assign axi_soc.wdata   = axi_in.wdata;
  assign axi_soc.wstrb   = axi_in.wstrb;
  assign axi_soc.wlast   = axi_in.wlast;
  assign axi_soc.bready  = wr_soc & axi_in.bready;

  assign axi_clint.awvalid = 1'b0;
  assign axi_clint.awaddr  = '0;
  assign axi_clint.awid    = '0;
  assign axi_clint.awlen   = '0;
  assign axi_clint.awsize  = '0;
  assign axi_clint.awburst = '0;
  assign axi_clint.wvalid  = 1'b0;
  assign axi_clint.wdata   = '0;
  assign axi_clint.wstrb   = '0;
  assign axi_clint.wlast   = 1'b0;
  assign axi_clint.bready  = 1'b0;

  assign axi_in.awready = (wr_soc & axi_soc.awready) | err_awready;
  assign axi_in.wready  = (wr_soc & axi_soc.wready)  | err_wready;
  assign axi_in.bvalid  = (wr_soc & axi_soc.bvalid)  | err_bvalid;
  assign axi_in.bresp   = wr_soc ? axi_soc.bresp : err_bresp;
  assign axi_in.bid     = wr_soc ? axi_soc.bid   : err_bid;

  // The CLINT write channels are never used, so its responses are ignored.
  logic unused_clint;
  assign unused_clint = ^{axi_clint.awready, axi_clint.wready, axi_clint.bvalid,
                          axi_clint.bresp, axi_clint.bid};

endmodule
